// File: rtl/memory_access_unit_if.sv
// Data-memory port between the memory-stage access unit (master) and the data memory (slave).
// Request fields stay stable while mem_req is high and mem_ready is low.
interface memory_access_unit_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
);
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDRESS_BITS-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic                    mem_ready;
  logic                    mem_rvalid;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/memory_access_unit.sv
// Memory-stage data-memory controller: issues one load/store per op on the data-memory port,
// stalls the pipeline while it runs, and returns byte/half/word formatted load data.
module memory_access_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  store,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] store_data,
  memory_access_unit_if.master  mem,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_valid,
  output logic                  stall,
  output logic                  misaligned
);

  localparam int LANES     = DATA_WIDTH / 8;
  localparam int LANE_BITS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [ADDRESS_BITS-1:0] addr_reg;
  logic [LANE_BITS-1:0]    lane_reg;
  logic [2:0]              funct3_reg;
  logic                    we_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [LANES-1:0]        be_reg;
  logic [DATA_WIDTH-1:0]   load_data_reg;

  logic op_valid;
  logic is_byte;
  logic is_half;
  logic is_word;
  logic funct3_legal;
  logic align_err;
  logic op_bad;
  logic accept;
  logic req_active;
  logic capture;

  logic [DATA_WIDTH-1:0] wdata_calc;
  logic [LANES-1:0]      be_calc;
  logic [7:0]            rd_byte [LANES];
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;
  logic [DATA_WIDTH-1:0] load_fmt;

  // Address bits above the memory window do not reach the data memory.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[DATA_WIDTH-1:ADDRESS_BITS];

  // ---------------------------------------------------------------- decode
  assign op_valid = load | store;
  assign is_byte  = (funct3[1:0] == 2'b00);
  assign is_half  = (funct3[1:0] == 2'b01);
  assign is_word  = (funct3[1:0] == 2'b10);

  // Unsigned variants exist only for loads.
  always_comb begin
    funct3_legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: funct3_legal = 1'b1;
      3'b100, 3'b101:         funct3_legal = ~store;
      default:                funct3_legal = 1'b0;
    endcase
  end

  assign align_err  = (is_half & address[0]) | (is_word & (address[1:0] != 2'b00));
  assign op_bad     = op_valid & (~funct3_legal | align_err);
  assign misaligned = (state_reg == IDLE) & op_bad;
  assign accept     = (state_reg == IDLE) & op_valid & ~op_bad;

  // ---------------------------------------------------------------- byte lanes
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic                 HALF_SEL = 1'(gi / 2);
      localparam logic [LANE_BITS-1:0] LANE_SEL = LANE_BITS'(gi);

      // Replicate the narrow store datum across lanes; byte enables pick the live one.
      assign wdata_calc[8*gi +: 8] = is_word ? store_data[8*gi +: 8] :
                                     is_half ? store_data[8*(gi%2) +: 8] :
                                               store_data[7:0];

      assign be_calc[gi] = is_word
                         | (is_half & (address[1] == HALF_SEL))
                         | (is_byte & (address[LANE_BITS-1:0] == LANE_SEL));

      assign rd_byte[gi] = mem.mem_rdata[8*gi +: 8];
    end
  endgenerate

  // ---------------------------------------------------------------- load format
  always_comb begin
    sel_byte = rd_byte[lane_reg];
    sel_half = lane_reg[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    load_fmt = mem.mem_rdata;
    case (funct3_reg)
      3'b000:  load_fmt = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
      3'b001:  load_fmt = {{(DATA_WIDTH-16){sel_half[15]}}, sel_half};
      3'b100:  load_fmt = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
      3'b101:  load_fmt = {{(DATA_WIDTH-16){1'b0}}, sel_half};
      default: load_fmt = mem.mem_rdata;
    endcase
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    req_active = 1'b0;
    stall      = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          stall      = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        req_active = 1'b1;
        stall      = 1'b1;
        if (mem.mem_ready) begin
          if (we_reg) begin
            state_next = DONE;
          end else if (mem.mem_rvalid) begin
            // Memory answered in the acceptance cycle: skip WAIT.
            capture    = 1'b1;
            state_next = DONE;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (mem.mem_rvalid) begin
          capture    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_reg   <= '0;
      lane_reg   <= '0;
      funct3_reg <= '0;
      we_reg     <= 1'b0;
      wdata_reg  <= '0;
      be_reg     <= '0;
    end else if (accept) begin
      addr_reg   <= {address[ADDRESS_BITS-1:LANE_BITS], {LANE_BITS{1'b0}}};
      lane_reg   <= address[LANE_BITS-1:0];
      funct3_reg <= funct3;
      we_reg     <= store;
      wdata_reg  <= store ? wdata_calc : '0;
      be_reg     <= store ? be_calc : '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_data_reg <= '0;
    end else if (capture) begin
      load_data_reg <= load_fmt;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign mem.mem_req   = req_active;
  assign mem.mem_we    = we_reg;
  assign mem.mem_addr  = addr_reg;
  assign mem.mem_wdata = wdata_reg;
  assign mem.mem_be    = be_reg;

  assign load_data  = load_data_reg;
  assign load_valid = (state_reg == DONE) & ~we_reg;

endmodule

// File: tb/tb_memory_access_unit.sv
// Scoreboard bench for memory_access_unit: directed ops push expected bus requests and
// load results; a negedge monitor compares them as the DUT presents them.
module tb_memory_access_unit;

  logic        clock;
  logic        reset;
  logic        load;
  logic        store;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        load_valid;
  logic        stall;
  logic        misaligned;

  memory_access_unit_if #(.DATA_WIDTH(32), .ADDRESS_BITS(20)) mem_bus ();

  memory_access_unit #(.DATA_WIDTH(32), .ADDRESS_BITS(20)) dut (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .store      (store),
    .funct3     (funct3),
    .address    (address),
    .store_data (store_data),
    .mem        (mem_bus),
    .load_data  (load_data),
    .load_valid (load_valid),
    .stall      (stall),
    .misaligned (misaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [19:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  req_t        exp_req_q[$];
  logic [31:0] exp_load_q[$];
  req_t        mon_req;

  int compared   = 0;
  int mismatched = 0;
  int stall_cnt  = 0;
  int req_cnt    = 0;
  int lv_cnt     = 0;
  int mis_cnt    = 0;
  bit clr_req    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One stimulus cycle: inputs change 1ns after the rising edge.
  task automatic drive_cycle(input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] sd,
                             input logic rdy, input logic rv, input logic [31:0] rd);
    @(posedge clock);
    #1;
    if (clr_req) begin
      stall_cnt = 0;
      req_cnt   = 0;
      lv_cnt    = 0;
      mis_cnt   = 0;
      clr_req   = 1'b0;
    end
    load               = ld;
    store              = st;
    funct3             = f3;
    address            = a;
    store_data         = sd;
    mem_bus.mem_ready  = rdy;
    mem_bus.mem_rvalid = rv;
    mem_bus.mem_rdata  = rd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic push_req(input logic [19:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
    req_t r;
    r.addr  = a;
    r.we    = we;
    r.be    = be;
    r.wdata = wd;
    exp_req_q.push_back(r);
  endtask

  // Monitor: request fields checked every mem_req cycle, popped on handshake.
  always @(negedge clock) begin
    if (reset) begin
      if (stall)          stall_cnt++;
      if (misaligned)     mis_cnt++;
      if (mem_bus.mem_req) begin
        req_cnt++;
        if (exp_req_q.size() == 0) begin
          check("unexpected_req", 32'd1, 32'd0);
        end else begin
          mon_req = exp_req_q[0];
          check("mem_addr",  {12'h0, mem_bus.mem_addr}, {12'h0, mon_req.addr});
          check("mem_we",    {31'h0, mem_bus.mem_we},   {31'h0, mon_req.we});
          check("mem_be",    {28'h0, mem_bus.mem_be},   {28'h0, mon_req.be});
          check("mem_wdata", mem_bus.mem_wdata,         mon_req.wdata);
          if (mem_bus.mem_ready) begin
            $display("req  addr=0x%05h we=%0b be=%04b wdata=0x%08h",
                     mem_bus.mem_addr, mem_bus.mem_we, mem_bus.mem_be, mem_bus.mem_wdata);
            void'(exp_req_q.pop_front());
          end
        end
      end
      if (load_valid) begin
        lv_cnt++;
        if (exp_load_q.size() == 0) begin
          check("unexpected_load_valid", 32'd1, 32'd0);
        end else begin
          $display("load data=0x%08h", load_data);
          check("load_data", load_data, exp_load_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset              = 1'b0;
    load               = 1'b0;
    store              = 1'b0;
    funct3             = 3'b000;
    address            = 32'h0;
    store_data         = 32'h0;
    mem_bus.mem_ready  = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
    mem_bus.mem_rdata  = 32'h0;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_mem_req",    {31'h0, mem_bus.mem_req}, 32'h0);
    check("rst_stall",      {31'h0, stall},           32'h0);
    check("rst_load_valid", {31'h0, load_valid},      32'h0);
    check("rst_load_data",  load_data,                32'h0);
    check("rst_mem_be",     {28'h0, mem_bus.mem_be},  32'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    idle(2);

    // 1. LW 0x100, ready in cycle 1, rvalid two cycles later
    push_req(20'h00100, 1'b0, 4'b0000, 32'h0);
    exp_load_q.push_back(32'hDEADBEEF);
    clr_req = 1'b1;
    drive_cycle(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b0, 3'b000, 32'h0,   32'h0, 1'b1, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b0, 3'b000, 32'h0,   32'h0, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b0, 3'b000, 32'h0,   32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    idle(3);
    check("t1_stall_cycles", stall_cnt, 32'd4);
    check("t1_load_valid_pulses", lv_cnt, 32'd1);
    check("t1_load_data_held", load_data, 32'hDEADBEEF);

    // 2. LB then LBU at 0x103 with rdata 0x80FFFF00
    push_req(20'h00100, 1'b0, 4'b0000, 32'h0);
    exp_load_q.push_back(32'hFFFFFF80);
    drive_cycle(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b0, 3'b000, 32'h0,   32'h0, 1'b1, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b0, 3'b000, 32'h0,   32'h0, 1'b0, 1'b1, 32'h80FFFF00);
    idle(2);
    push_req(20'h00100, 1'b0, 4'b0000, 32'h0);
    exp_load_q.push_back(32'h00000080);
    drive_cycle(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b0, 3'b000, 32'h0,   32'h0, 1'b1, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b0, 3'b000, 32'h0,   32'h0, 1'b0, 1'b1, 32'h80FFFF00);
    idle(2);

    // 3. SH 0x202 with ready held low three cycles
    push_req(20'h00200, 1'b1, 4'b1100, 32'hABCDABCD);
    clr_req = 1'b1;
    drive_cycle(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b0, 3'b000, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b0, 3'b000, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b0, 3'b000, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b0, 3'b000, 32'h0,   32'h0,        1'b1, 1'b0, 32'h0);
    idle(3);
    check("t3_mem_req_cycles", req_cnt, 32'd4);
    check("t3_load_valid_pulses", lv_cnt, 32'd0);
    check("t3_stall_cycles", stall_cnt, 32'd5);

    // 4. Misaligned / illegal ops are dropped
    clr_req = 1'b1;
    drive_cycle(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b1, 3'b001, 32'h201, 32'h5, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0);
    idle(3);
    check("t4_misaligned_cycles", mis_cnt, 32'd3);
    check("t4_mem_req_cycles", req_cnt, 32'd0);
    check("t4_stall_cycles", stall_cnt, 32'd0);

    // 5. Ready and rvalid in the same cycle
    push_req(20'h00010, 1'b0, 4'b0000, 32'h0);
    exp_load_q.push_back(32'h00000005);
    clr_req = 1'b1;
    drive_cycle(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b0, 3'b000, 32'h0,  32'h0, 1'b1, 1'b1, 32'h5);
    idle(3);
    check("t5_stall_cycles", stall_cnt, 32'd2);
    check("t5_load_valid_pulses", lv_cnt, 32'd1);

    // 6. Reset during WAIT, late rvalid afterwards
    push_req(20'h00300, 1'b0, 4'b0000, 32'h0);
    clr_req = 1'b1;
    drive_cycle(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b0, 3'b000, 32'h0,   32'h0, 1'b1, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b0, 3'b000, 32'h0,   32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("t6_rst_mem_req",   {31'h0, mem_bus.mem_req}, 32'h0);
    check("t6_rst_stall",     {31'h0, stall},           32'h0);
    check("t6_rst_load_data", load_data,                32'h0);
    check("t6_rst_mem_addr",  {12'h0, mem_bus.mem_addr}, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    drive_cycle(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b1, 32'h00000077);
    idle(3);
    check("t6_load_valid_pulses", lv_cnt, 32'd0);
    check("t6_load_data_after", load_data, 32'h0);
    check("t6_mem_req_cycles", req_cnt, 32'd1);

    check("req_queue_drained",  exp_req_q.size(),  32'd0);
    check("load_queue_drained", exp_load_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
